// File: rtl/seq_mult_if.sv
// -----------------------------------------------------------------------------
// seq_mult_if
// Handshake bundle for the sequential shift-add multiplier.
//   m, q         operands (WIDTH bits), sampled on the input handshake
//   signed_mode  1 = two's-complement operation, 0 = unsigned
//   in_valid     producer has operands available
//   in_ready     multiplier can accept operands
//   p            registered product (2*WIDTH bits)
//   out_valid    p holds a completed product
//   out_ready    consumer accepts p
//   busy         an operation is in flight (CALC or DONE)
// master: the front end / consumer side; slave: the multiplier.
// -----------------------------------------------------------------------------
interface seq_mult_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0]   m;
   logic [WIDTH-1:0]   q;
   logic               signed_mode;
   logic               in_valid;
   logic               in_ready;
   logic [2*WIDTH-1:0] p;
   logic               out_valid;
   logic               out_ready;
   logic               busy;

   modport master (
      output m, q, signed_mode, in_valid, out_ready,
      input  in_ready, p, out_valid, busy
   );

   modport slave (
      input  m, q, signed_mode, in_valid, out_ready,
      output in_ready, p, out_valid, busy
   );
endinterface

// File: rtl/seq_mult.sv
// -----------------------------------------------------------------------------
// seq_mult
// Sequential shift-add multiplier, one partial product per clock.
// Signed operands are reduced to magnitudes on accept; the sign of the
// product is reapplied with a single negation on the final step.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  seq_mult_if.slave: operand handshake (m, q, signed_mode,
//        in_valid/in_ready), result handshake (p, out_valid/out_ready), busy
// Latency: WIDTH cycles from accept to out_valid; throughput one product per
// WIDTH+2 cycles with out_ready held high.
// -----------------------------------------------------------------------------
module seq_mult #(
   parameter int WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   seq_mult_if.slave  bus
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   mcand;      // magnitude of the multiplicand
   logic [WIDTH-1:0]   mplier;     // magnitude of the multiplier, shifted right each step
   logic               neg;        // product sign; the mode only matters through this bit
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [CNT_W-1:0]   cnt;
   logic               in_ready_r;
   logic               out_valid_r;
   logic               busy_r;
   logic [2*WIDTH-1:0] p_r;

   // Two's-complement magnitude returned as an unsigned WIDTH-bit value.
   // The most negative input maps to 2^(WIDTH-1), which still fits unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
      logic signed [WIDTH-1:0] negx;
      negx = -x;
      return x[WIDTH-1] ? WIDTH'(negx) : WIDTH'(x);
   endfunction

   // Applies the product sign; wraps modulo 2^(2*WIDTH), which is exact for
   // every legal operand pair.
   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                     input logic              s);
      return s ? (~mag + 1'b1) : mag;
   endfunction

   // Partial product for the current step: multiplicand shifted by the count.
   always_comb begin
      acc_next = acc;
      if (mplier[0])
         acc_next = acc + ({{WIDTH{1'b0}}, mcand} << cnt);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mcand       <= '0;
         mplier      <= '0;
         neg         <= 1'b0;
         acc         <= '0;
         cnt         <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         p_r         <= '0;
      end else begin
         case (state)
            // ---- IDLE: accept operands ----
            IDLE: begin
               in_ready_r <= 1'b1;
               if (bus.in_valid && in_ready_r) begin
                  if (bus.signed_mode) begin
                     mcand <= magnitude($signed(bus.m));
                     mplier <= magnitude($signed(bus.q));
                     neg    <= bus.m[WIDTH-1] ^ bus.q[WIDTH-1];
                  end else begin
                     mcand  <= bus.m;
                     mplier <= bus.q;
                     neg    <= 1'b0;
                  end
                  acc        <= '0;
                  cnt        <= '0;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state      <= CALC;
               end
            end

            // ---- CALC: one shift-add step per clock ----
            CALC: begin
               acc    <= acc_next;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_STEP) begin
                  p_r         <= apply_sign(acc_next, neg);
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end
            end

            // ---- DONE: hold product until the consumer takes it ----
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end

            default: begin
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.p         = p_r;

endmodule

// File: tb/tb_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_mult
// Directed bench for seq_mult at WIDTH=4 and WIDTH=8. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_seq_mult;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   seq_mult_if #(.WIDTH(4)) ifc4 ();
   seq_mult_if #(.WIDTH(8)) ifc8 ();

   seq_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(ifc4.slave));
   seq_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(ifc8.slave));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full transaction on the WIDTH=4 instance: accept, check latency and
   // product, then a one-cycle output handshake. Starts and ends on a negedge.
   task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                       input logic [7:0] exp, input string tag);
      int lat;
      check({tag, "_in_ready"}, 32'(ifc4.in_ready), 32'd1);
      ifc4.m = a; ifc4.q = b; ifc4.signed_mode = sm; ifc4.in_valid = 1'b1;
      @(negedge clk);
      ifc4.in_valid = 1'b0;
      check({tag, "_busy"}, 32'(ifc4.busy), 32'd1);
      lat = 0;
      while (!ifc4.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd4);
      check({tag, "_p"}, 32'(ifc4.p), 32'(exp));
      ifc4.out_ready = 1'b1;
      @(negedge clk);
      ifc4.out_ready = 1'b0;
      check({tag, "_idle"}, {29'd0, ifc4.out_valid, ifc4.busy, ifc4.in_ready}, 32'b001);
   endtask

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [15:0] exp, input string tag);
      int lat;
      check({tag, "_in_ready"}, 32'(ifc8.in_ready), 32'd1);
      ifc8.m = a; ifc8.q = b; ifc8.signed_mode = sm; ifc8.in_valid = 1'b1;
      @(negedge clk);
      ifc8.in_valid = 1'b0;
      lat = 0;
      while (!ifc8.out_valid && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd8);
      check({tag, "_p"}, 32'(ifc8.p), 32'(exp));
      ifc8.out_ready = 1'b1;
      @(negedge clk);
      ifc8.out_ready = 1'b0;
      check({tag, "_idle"}, {30'd0, ifc8.out_valid, ifc8.in_ready}, 32'b01);
   endtask

   initial begin
      int sa, sb;
      logic [7:0] ref_p;
      logic [7:0] held_p;

      ifc4.m = '0; ifc4.q = '0; ifc4.signed_mode = 1'b0; ifc4.in_valid = 1'b0; ifc4.out_ready = 1'b0;
      ifc8.m = '0; ifc8.q = '0; ifc8.signed_mode = 1'b0; ifc8.in_valid = 1'b0; ifc8.out_ready = 1'b0;

      // Reset state
      #2;
      check("reset_p", 32'(ifc4.p), 32'd0);
      check("reset_ctl", {29'd0, ifc4.out_valid, ifc4.busy, ifc4.in_ready}, 32'b000);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_in_ready", 32'(ifc4.in_ready), 32'd1);

      // Unsigned and signed corner products
      run4(4'd15, 4'd15, 1'b0, 8'hE1, "u_15x15");
      run4(4'b1000, 4'b1000, 1'b1, 8'h40, "s_m8xm8");
      run4(4'b1111, 4'b0111, 1'b1, 8'hF9, "s_m1x7");
      run4(4'b1000, 4'b0111, 1'b1, 8'hC8, "s_m8x7");

      // Backpressure: result held for 5 cycles, new operands ignored
      ifc4.m = 4'd3; ifc4.q = 4'd5; ifc4.signed_mode = 1'b0; ifc4.in_valid = 1'b1;
      @(negedge clk);
      ifc4.m = 4'd7; ifc4.q = 4'd9;
      repeat (4) @(negedge clk);
      check("bp_valid", 32'(ifc4.out_valid), 32'd1);
      held_p = ifc4.p;
      check("bp_p", 32'(held_p), 32'h0F);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold", {22'd0, ifc4.p, ifc4.out_valid, ifc4.in_ready}, {22'd0, 8'h0F, 2'b10});
      end
      ifc4.in_valid = 1'b0;
      ifc4.out_ready = 1'b1;
      @(negedge clk);
      ifc4.out_ready = 1'b0;
      check("bp_release", {30'd0, ifc4.out_valid, ifc4.in_ready}, 32'b01);
      check("bp_p_after", 32'(ifc4.p), 32'h0F);
      run4(4'd7, 4'd9, 1'b0, 8'h3F, "bp_next");

      // Reset mid-operation
      ifc4.m = 4'd9; ifc4.q = 4'd5; ifc4.signed_mode = 1'b0; ifc4.in_valid = 1'b1;
      @(negedge clk);
      ifc4.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_p", 32'(ifc4.p), 32'd0);
      check("abort_ctl", {29'd0, ifc4.out_valid, ifc4.busy, ifc4.in_ready}, 32'b000);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_recover", {29'd0, ifc4.out_valid, ifc4.busy, ifc4.in_ready}, 32'b001);
      run4(4'd9, 4'd5, 1'b0, 8'h2D, "after_abort");

      // Exhaustive sweep, both modes, against an integer reference
      for (int md = 0; md < 2; md++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               if (md == 1) begin
                  sa = (a > 7) ? a - 16 : a;
                  sb = (b > 7) ? b - 16 : b;
               end else begin
                  sa = a;
                  sb = b;
               end
               ref_p = 8'(sa * sb);
               run4(4'(a), 4'(b), 1'(md), ref_p, $sformatf("sweep_m%0d_%0d_%0d", md, a, b));
            end
         end
      end

      // WIDTH=8 spot checks
      run8(8'd255, 8'd255, 1'b0, 16'hFE01, "w8_u_255x255");
      run8(8'h80, 8'h80, 1'b1, 16'h4000, "w8_s_m128xm128");
      run8(8'h80, 8'h7F, 1'b1, 16'hC080, "w8_s_m128x127");
      run8(8'd0, 8'd200, 1'b0, 16'h0000, "w8_u_0x200");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential shift-add multiplier with valid/ready handshakes on both sides and a per-operation signed/unsigned mode. It is the area-reduced, multi-cycle successor to the combinational 4-bit array multiplier. It computes one partial product per clock, so that wide operands fit the tile budget. It sits between an operand-producing front end and a result consumer that may apply backpressure.

## Interface
- WIDTH, 4: operand width in bits; legal range 2..16; product width is 2*WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- m  in  WIDTH  multiplicand; sampled only on input handshake.
- q  in  WIDTH  multiplier; sampled only on input handshake.
- signed_mode  in  1  1 = two's-complement operands and product, 0 = unsigned; sampled on input handshake.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- p  out  2*WIDTH  registered product.
- out_valid  out  1  p holds a completed product.
- out_ready  in  1  consumer accepts p.
- busy  out  1  high in CALC or DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: iterate WIDTH steps.
  - DONE: out_valid=1, hold result.
- Transitions:
  - IDLE -> CALC on in_valid && in_ready.
  - CALC -> DONE when the step counter reaches WIDTH-1.
  - DONE -> IDLE on out_valid && out_ready.
  - No other transitions.
- Accept:
  - Latch mode.
  - In signed mode, latch |m| and |q| as WIDTH-bit unsigned magnitudes, and latch neg = m[WIDTH-1] ^ q[WIDTH-1].
  - In unsigned mode, latch m and q directly, neg=0.
  - Clear the 2*WIDTH accumulator and the counter.
- Magnitude of the most negative value (-2^(WIDTH-1)) is 2^(WIDTH-1). It fits in WIDTH unsigned bits and must not overflow.
- Each CALC cycle:
  - If the current LSB of the shifted multiplier is 1, add the magnitude-multiplicand, shifted left by the counter value, into the accumulator.
  - Shift the multiplier right by one and increment the counter.
- On the final CALC step, register p = neg ? -(acc_final) : acc_final, modulo 2^(2*WIDTH).
- Signed results are always exact in 2*WIDTH bits; unsigned results are always exact.
- in_ready is low in CALC and DONE; inputs are ignored there, and in_valid may stay high without effect.
- p and out_valid change only on a clock edge. p holds its value through DONE regardless of out_ready, and holds its last value in IDLE until the next result is written.
- Multiplying by 0 still takes the full WIDTH cycles; there is no early termination.

## Timing
- Reset while rst=1, asynchronous:
  - state=IDLE, p=0, out_valid=0, busy=0, counter=0, accumulator=0.
  - in_ready is forced 0 while rst is asserted and becomes 1 in the first cycle after deassertion.
- Latency:
  - Input handshake at edge E0.
  - CALC occupies edges E1..E_WIDTH.
  - out_valid and the valid p are visible after edge E_WIDTH, i.e. WIDTH cycles after acceptance.
- Output handshake at edge E_D returns to IDLE. in_ready=1 after E_D. The earliest next accept is edge E_D+1.
- Maximum throughput is one product per WIDTH+2 cycles when out_ready is held high.
- Reset asserted mid-CALC or in DONE aborts the operation immediately. No partial or stale out_valid is ever produced afterwards.
- out_ready asserted outside DONE has no effect.

## Test plan
- WIDTH=4, unsigned, m=15, q=15 → p=8'hE1. out_valid rises exactly 4 cycles after accept. busy is high from accept until the output handshake.
- WIDTH=4, signed:
  - m=4'b1000 (-8), q=4'b1000 (-8) → p=8'h40.
  - m=4'b1111 (-1), q=4'b0111 (7) → p=8'hF9.
  - m=4'b1000, q=4'b0111 → p=8'hC8 (-56).
- Backpressure: hold out_ready=0 for 5 cycles in DONE → p and out_valid stable, in_ready=0, new in_valid with different operands ignored. Then pulse out_ready → IDLE, next product correct.
- Reset mid-operation: accept m=9, q=5, assert rst after 2 CALC cycles → all outputs reset immediately. After release, accept m=9, q=5 → p=8'h2D with no spurious out_valid in between.
- Exhaustive sweep, WIDTH=4, both modes, all 256 operand pairs, back-to-back with out_ready=1 → every p matches the reference model. Each result takes exactly 6 cycles from one accept to the next.
- WIDTH=8 spot checks:
  - unsigned 255*255 → 16'hFE01.
  - signed -128*-128 → 16'h4000.
  - signed -128*127 → 16'hC080.
  - unsigned 0*200 → 0 after 8 cycles.
